// File: rtl/combo_lock_ctrl_pkg.sv
// Shared types and constants for the combination-lock controller.
package combo_lock_pkg;

   typedef enum logic [1:0] {LOCKED, OPEN, FAIL, LOCKOUT} lock_state_e;

   // LED words are ordered {led_1, led_3, led_5, led_7, led_9}
   localparam logic [4:0] LED_ALL  = 5'b11111;
   localparam logic [4:0] LED_FAIL = 5'b10101;
   localparam logic [4:0] LED_OFF  = 5'b00000;

   // Bits needed to hold the largest of three cycle counts (at least 1).
   function automatic int timer_width(input int unsigned a, input int unsigned b,
                                      input int unsigned c);
      longint unsigned m;
      int w;
      m = 64'(a);
      if (64'(b) > m) m = 64'(b);
      if (64'(c) > m) m = 64'(c);
      w = 1;
      while ((64'd1 << w) < m) w++;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for one raw input.
module btn_debounce
   import combo_lock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic press
);

   localparam int CW = timer_width(DEBOUNCE_CYCLES, 1, 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level;

   // cnt tracks consecutive cycles where the synchronized input disagrees with level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], din};
         press <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync[1];
            press <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: OPEN / FAIL / LOCKOUT phases on a shared down-counter.
// Define CODE_PROGRAM_EN to let a press in OPEN store the switch word as the new code.
module combo_lock_ctrl
   import combo_lock_pkg::*;
#(
   parameter logic [4:0]  CODE            = 5'b11111,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned OPEN_CYCLES     = 50000000,
   parameter int unsigned FAIL_CYCLES     = 25000000,
   parameter int unsigned LOCKOUT_CYCLES  = 250000000,
   parameter int unsigned MAX_TRIES       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_1,
   input  logic       sw_3,
   input  logic       sw_5,
   input  logic       sw_7,
   input  logic       sw_9,
   input  logic       btn,
   output logic       led_1,
   output logic       led_3,
   output logic       led_5,
   output logic       led_7,
   output logic       led_9,
   output logic       unlocked,
   output logic       locked_out,
   output logic [2:0] fail_cnt
);

   localparam int TW = timer_width(OPEN_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES);
   localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] T_FAIL = TW'(FAIL_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    MAX3   = 3'(MAX_TRIES);

   lock_state_e   state;
   logic [TW-1:0] timer;
   logic [4:0]    led;
   logic [4:0]    sw_meta, sw_word, code;
   logic [2:0]    fail_inc;
   logic          press;

   assign {led_1, led_3, led_5, led_7, led_9} = led;
   assign fail_inc = fail_cnt + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta <= '0;
         sw_word <= '0;
      end else begin
         sw_meta <= {sw_1, sw_3, sw_5, sw_7, sw_9};
         sw_word <= sw_meta;
      end
   end

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn),
      .press (press)
   );

`ifdef CODE_PROGRAM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         code <= CODE;
      else if (state == OPEN && press)
         code <= sw_word;
   end
`else
   assign code = CODE;
`endif

   // Outputs are assigned alongside the state so they decode the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOCKED;
         timer      <= '0;
         fail_cnt   <= '0;
         led        <= LED_OFF;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         case (state)
            LOCKED: begin
               if (press) begin
                  if (sw_word == code) begin
                     state    <= OPEN;
                     fail_cnt <= '0;
                     timer    <= T_OPEN;
                     led      <= LED_ALL;
                     unlocked <= 1'b1;
                  end else if (fail_inc < MAX3) begin
                     state    <= FAIL;
                     fail_cnt <= fail_inc;
                     timer    <= T_FAIL;
                     led      <= LED_FAIL;
                  end else begin
                     state      <= LOCKOUT;
                     fail_cnt   <= MAX3;
                     timer      <= T_LOCK;
                     led        <= LED_OFF;
                     locked_out <= 1'b1;
                  end
               end
            end
            OPEN: begin
               if (press || timer == '0) begin
                  state    <= LOCKED;
                  timer    <= '0;
                  led      <= LED_OFF;
                  unlocked <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            FAIL: begin
               if (timer == '0) begin
                  state <= LOCKED;
                  led   <= LED_OFF;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            LOCKOUT: begin
               if (timer == '0) begin
                  state      <= LOCKED;
                  fail_cnt   <= '0;
                  locked_out <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               state      <= LOCKED;
               timer      <= '0;
               led        <= LED_OFF;
               unlocked   <= 1'b0;
               locked_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
